// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment scanner: CPU-written hex value, frame-synchronous shadow copy,
// leading-zero blanking, per-digit decimal points and PWM brightness on active-low pins.
module seg_display_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 4,
    parameter int BRIGHT_W   = 3
) (
    input  logic                    clock1KHz,
    input  logic                    RAMclr,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzb_en,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int CMP_W   = (DWELL_W > BRIGHT_W) ? DWELL_W : BRIGHT_W;

    logic [4*NUM_DIGITS-1:0] value_reg;
    logic [NUM_DIGITS-1:0]   dp_reg;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [IDX_W-1:0]        idx;
    logic [DWELL_W-1:0]      dwell;

    logic                    last_dwell;
    logic                    last_idx;
    logic                    frame_wrap;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_above;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   dig_next;
    logic [7:0]              seg_next;

    function automatic logic [6:0] enc(input logic [3:0] hex);
        case (hex)
            4'h0: enc = 7'h3F;
            4'h1: enc = 7'h06;
            4'h2: enc = 7'h5B;
            4'h3: enc = 7'h4F;
            4'h4: enc = 7'h66;
            4'h5: enc = 7'h6D;
            4'h6: enc = 7'h7D;
            4'h7: enc = 7'h07;
            4'h8: enc = 7'h7F;
            4'h9: enc = 7'h6F;
            4'hA: enc = 7'h77;
            4'hB: enc = 7'h7C;
            4'hC: enc = 7'h39;
            4'hD: enc = 7'h5E;
            4'hE: enc = 7'h79;
            default: enc = 7'h71;
        endcase
    endfunction

    assign last_dwell = (dwell == DWELL_W'(DWELL - 1));
    assign last_idx   = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_wrap = last_dwell && last_idx;

    always_ff @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            value_reg <= '0;
            dp_reg    <= '0;
        end else if (wr_en) begin
            value_reg <= wr_data;
            dp_reg    <= dp_in;
        end
    end

    // The shadow only changes at the frame boundary so a frame never mixes two values.
    always_ff @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            shadow     <= '0;
            shadow_dp  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (frame_wrap) begin
                shadow    <= value_reg;
                shadow_dp <= dp_reg;
            end
        end
    end

    always_ff @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            idx   <= '0;
            dwell <= '0;
        end else if (last_dwell) begin
            dwell <= '0;
            idx   <= last_idx ? '0 : idx + 1'b1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit blanks only while everything above it is zero.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (shadow[4*i +: 4] == 4'h0);
            if (i != 0) begin
                blank[i] = lzb_en && zero_above;
            end
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = shadow[4*i +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = blank[i];
            end
        end
        lit = (CMP_W'(dwell) < CMP_W'(bright)) && !cur_blank;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_next[i] = !(lit && (idx == IDX_W'(i)));
        end
        seg_next = lit ? {~cur_dp, ~enc(cur_nib)} : 8'hFF;
    end

    always_ff @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            dig <= '1;
            seg <= 8'hFF;
        end else begin
            dig <= dig_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: a 4-digit and an 8-digit instance checked every cycle against a
// frame-position reference model, plus decode vectors and hand-written scan sequences.
module tb_seg_display_scanner;

    logic        clock1KHz = 1'b0;
    logic        RAMclr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  dp_in;
    logic        lzb_en;
    logic [2:0]  bright;
    logic [3:0]  dig;
    logic [7:0]  seg;
    logic        frame_done;

    logic        wr_en8;
    logic [31:0] wr_data8;
    logic [7:0]  dp_in8;
    logic        lzb_en8;
    logic [2:0]  bright8;
    logic [7:0]  dig8;
    logic [7:0]  seg8;
    logic        frame_done8;

    int pass_count = 0;
    int check_count = 0;

    localparam logic [6:0] ENC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic            lzb;
        logic [2:0]      br;
        logic [3:0][7:0] seg;
    } vec_t;

    vec_t vecs [7];

    seg_display_scanner #(.NUM_DIGITS(4), .DWELL(4), .BRIGHT_W(3)) dut4 (
        .clock1KHz(clock1KHz), .RAMclr(RAMclr), .wr_en(wr_en), .wr_data(wr_data),
        .dp_in(dp_in), .lzb_en(lzb_en), .bright(bright), .dig(dig), .seg(seg),
        .frame_done(frame_done)
    );

    seg_display_scanner #(.NUM_DIGITS(8), .DWELL(2), .BRIGHT_W(3)) dut8 (
        .clock1KHz(clock1KHz), .RAMclr(RAMclr), .wr_en(wr_en8), .wr_data(wr_data8),
        .dp_in(dp_in8), .lzb_en(lzb_en8), .bright(bright8), .dig(dig8), .seg(seg8),
        .frame_done(frame_done8)
    );

    always #5 clock1KHz = ~clock1KHz;

    // Expected pins for frame position p: digit p/d, dwell slot p%d.
    function automatic void refOut(input int n, input int d, input int p, input logic [31:0] sh,
                                   input logic [7:0] sdp, input logic lzb, input int br,
                                   output logic [7:0] edig, output logic [7:0] eseg);
        int i;
        int w;
        logic [31:0] upper;
        logic [3:0] nib;
        i = p / d;
        w = p % d;
        upper = sh >> (4 * i);
        nib = upper[3:0];
        edig = 8'hFF;
        eseg = 8'hFF;
        if (n > 0 && w < br && !(lzb && i > 0 && upper == 32'h0)) begin
            edig[i] = 1'b0;
            eseg = {~sdp[i], ~ENC[nib]};
        end
    endfunction

    int m4_cyc, m4_p;
    logic [31:0] m4_val, m4_sh;
    logic [7:0] m4_dp, m4_shdp, m4_dig, m4_seg;
    logic m4_fd;

    always @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            m4_cyc = 0; m4_val = 0; m4_dp = 0; m4_sh = 0; m4_shdp = 0;
            m4_dig = 8'hFF; m4_seg = 8'hFF; m4_fd = 1'b0;
        end else begin
            m4_p = m4_cyc % 16;
            refOut(4, 4, m4_p, m4_sh, m4_shdp, lzb_en, int'(bright), m4_dig, m4_seg);
            m4_fd = (m4_p == 15);
            if (m4_fd) begin
                m4_sh = m4_val;
                m4_shdp = m4_dp;
            end
            if (wr_en) begin
                m4_val = {16'h0, wr_data};
                m4_dp = {4'h0, dp_in};
            end
            m4_cyc++;
        end
    end

    int m8_cyc, m8_p;
    logic [31:0] m8_val, m8_sh;
    logic [7:0] m8_dp, m8_shdp, m8_dig, m8_seg;
    logic m8_fd;

    always @(posedge clock1KHz or posedge RAMclr) begin
        if (RAMclr) begin
            m8_cyc = 0; m8_val = 0; m8_dp = 0; m8_sh = 0; m8_shdp = 0;
            m8_dig = 8'hFF; m8_seg = 8'hFF; m8_fd = 1'b0;
        end else begin
            m8_p = m8_cyc % 16;
            refOut(8, 2, m8_p, m8_sh, m8_shdp, lzb_en8, int'(bright8), m8_dig, m8_seg);
            m8_fd = (m8_p == 15);
            if (m8_fd) begin
                m8_sh = m8_val;
                m8_shdp = m8_dp;
            end
            if (wr_en8) begin
                m8_val = wr_data8;
                m8_dp = dp_in8;
            end
            m8_cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        else
            pass_count++;
    endtask

    task automatic step();
        @(negedge clock1KHz);
        checkOutput("model4_dig", {28'h0, dig}, {28'h0, m4_dig[3:0]});
        checkOutput("model4_seg", {24'h0, seg}, {24'h0, m4_seg});
        checkOutput("model4_frame_done", {31'h0, frame_done}, {31'h0, m4_fd});
        checkOutput("model8_dig", {24'h0, dig8}, {24'h0, m8_dig});
        checkOutput("model8_seg", {24'h0, seg8}, {24'h0, m8_seg});
        checkOutput("model8_frame_done", {31'h0, frame_done8}, {31'h0, m8_fd});
    endtask

    task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp, input logic lzb,
                                 input logic [2:0] br, input logic we);
        wr_data = data;
        dp_in = dp;
        lzb_en = lzb;
        bright = br;
        wr_en = we;
    endtask

    task automatic waitFrame4();
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = frame_done;
        end
        checkOutput("frame4_wait", {31'h0, found}, 32'h1);
    endtask

    task automatic waitFrame8();
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            found = frame_done8;
        end
        checkOutput("frame8_wait", {31'h0, found}, 32'h1);
    endtask

    // Starts right after a frame_done sample; the next 16 samples are positions 0..15.
    task automatic sampleFrame(output logic [3:0][7:0] segs, output logic [3:0][3:0] digs, output int lit);
        lit = 0;
        segs = '1;
        digs = '1;
        for (int c = 0; c < 16; c++) begin
            step();
            if (c % 4 == 0) begin
                segs[c/4] = seg;
                digs[c/4] = dig;
            end
            if (dig != 4'hF) lit++;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0][7:0] segs;
        logic [3:0][3:0] digs;
        logic [3:0] exp_dig;
        logic [7:0] exp8 [8];
        int lit;
        int len;

        vecs[0] = '{16'h12AB, 4'h0, 1'b0, 3'd4, {8'hF9, 8'hA4, 8'h88, 8'h83}};
        vecs[1] = '{16'h0005, 4'h0, 1'b1, 3'd4, {8'hFF, 8'hFF, 8'hFF, 8'h92}};
        vecs[2] = '{16'h0000, 4'h0, 1'b1, 3'd4, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{16'h0005, 4'h0, 1'b0, 3'd4, {8'hC0, 8'hC0, 8'hC0, 8'h92}};
        vecs[4] = '{16'h12AB, 4'h4, 1'b0, 3'd7, {8'hF9, 8'h24, 8'h88, 8'h83}};
        vecs[5] = '{16'h1111, 4'hF, 1'b1, 3'd4, {8'h79, 8'h79, 8'h79, 8'h79}};
        vecs[6] = '{16'h0F00, 4'hF, 1'b1, 3'd4, {8'hFF, 8'h0E, 8'h40, 8'h40}};
        exp8 = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

        RAMclr = 1'b1;
        applyStimulus(16'h0, 4'h0, 1'b0, 3'd4, 1'b0);
        wr_en8 = 1'b0; wr_data8 = 32'h0; dp_in8 = 8'h0; lzb_en8 = 1'b0; bright8 = 3'd2;
        #2;
        checkOutput("reset_dig", {28'h0, dig}, 32'hF);
        checkOutput("reset_seg", {24'h0, seg}, 32'hFF);
        checkOutput("reset_frame_done", {31'h0, frame_done}, 32'h0);
        @(negedge clock1KHz);
        RAMclr = 1'b0;

        for (int k = 0; k < 10; k++) step();
        #1 RAMclr = 1'b1;
        #1;
        checkOutput("midreset_dig", {28'h0, dig}, 32'hF);
        checkOutput("midreset_seg", {24'h0, seg}, 32'hFF);
        checkOutput("midreset_frame_done", {31'h0, frame_done}, 32'h0);
        checkOutput("midreset_dig8", {24'h0, dig8}, 32'hFF);
        #1 RAMclr = 1'b0;
        step();
        checkOutput("first_digit0", {28'h0, dig}, 32'hE);
        checkOutput("first_digit0_seg", {24'h0, seg}, 32'hC0);
        checkOutput("first_digit0_dig8", {24'h0, dig8}, 32'hFE);

        waitFrame4();
        len = 0;
        do begin
            step();
            len++;
        end while (!frame_done && len < 40);
        checkOutput("frame4_length", len, 16);

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].data, vecs[v].dp, vecs[v].lzb, vecs[v].br, 1'b1);
            step();
            wr_en = 1'b0;
            waitFrame4();
            waitFrame4();
            sampleFrame(segs, digs, lit);
            for (int d = 0; d < 4; d++) begin
                exp_dig = 4'hF;
                if (vecs[v].seg[d] != 8'hFF) exp_dig[d] = 1'b0;
                checkOutput($sformatf("vec%0d_seg%0d", v, d), {24'h0, segs[d]}, {24'h0, vecs[v].seg[d]});
                checkOutput($sformatf("vec%0d_dig%0d", v, d), {28'h0, digs[d]}, {28'h0, exp_dig});
            end
        end

        applyStimulus(16'h12AB, 4'h0, 1'b0, 3'd1, 1'b1);
        step();
        wr_en = 1'b0;
        waitFrame4();
        waitFrame4();
        sampleFrame(segs, digs, lit);
        checkOutput("bright1_lit", lit, 4);
        checkOutput("bright1_seg1", {24'h0, segs[1]}, 32'h88);
        bright = 3'd0;
        waitFrame4();
        sampleFrame(segs, digs, lit);
        checkOutput("bright0_lit", lit, 0);
        bright = 3'd7;
        waitFrame4();
        sampleFrame(segs, digs, lit);
        checkOutput("bright7_lit", lit, 16);
        bright = 3'd4;
        waitFrame4();
        sampleFrame(segs, digs, lit);
        checkOutput("bright4_lit", lit, 16);

        waitFrame4();
        step();
        step();
        applyStimulus(16'h1111, 4'h0, 1'b0, 3'd4, 1'b1);
        step();
        wr_en = 1'b0;
        step();
        step();
        checkOutput("tear_old_digit1", {24'h0, seg}, 32'h88);
        waitFrame4();
        for (int k = 0; k < 5; k++) step();
        checkOutput("tear_new_digit1", {24'h0, seg}, 32'hF9);
        for (int k = 0; k < 10; k++) step();
        applyStimulus(16'h2222, 4'h0, 1'b0, 3'd4, 1'b1);
        step();
        wr_en = 1'b0;
        checkOutput("wrap_write_frame_done", {31'h0, frame_done}, 32'h1);
        for (int k = 0; k < 5; k++) step();
        checkOutput("wrap_write_still_old", {24'h0, seg}, 32'hF9);
        waitFrame4();
        for (int k = 0; k < 5; k++) step();
        checkOutput("wrap_write_new", {24'h0, seg}, 32'hA4);

        wr_data8 = 32'h89ABCDEF;
        wr_en8 = 1'b1;
        step();
        wr_en8 = 1'b0;
        waitFrame8();
        waitFrame8();
        for (int c = 0; c < 16; c++) begin
            step();
            if (c % 2 == 0) begin
                checkOutput($sformatf("d8_seg%0d", c / 2), {24'h0, seg8}, {24'h0, exp8[c/2]});
                checkOutput($sformatf("d8_dig%0d", c / 2), {24'h0, dig8}, {24'h0, ~(8'h01 << (c / 2))});
            end
        end
        len = 0;
        do begin
            step();
            len++;
        end while (!frame_done8 && len < 40);
        checkOutput("frame8_length", len, 16);

        for (int k = 0; k < 400; k++) begin
            applyStimulus(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom),
                          1'($urandom), 3'($urandom), $urandom_range(0, 3) == 0);
            wr_data8 = $urandom >> (4 * $urandom_range(0, 8));
            dp_in8 = 8'($urandom);
            lzb_en8 = 1'($urandom);
            bright8 = 3'($urandom);
            wr_en8 = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
